param_data_path: RTL and testbench
==================================

# param_data_path

Parametrised multicycle CPU data path: program counter, instruction register, multi-register file, shared ALU with zero/carry flags, and a handshaked external data-memory port with its own access sequencer. It sits under the CPU top level, driven cycle-by-cycle by the controller FSM. The controller decodes `opcode` and flags; all storage and memory sequencing live here.

## Interface
- `DATA_W`, 8: datapath, register, PC and memory-word width (≥4)
- `NUM_REGS`, 4: register-file entries (power of two, ≥2); `RA_W = $clog2(NUM_REGS)`
- `TIMEOUT_CYCLES`, 15: memory wait limit (used only with `DP_MEM_TIMEOUT_EN`)
- `clk`  input  1  clock
- `reset`  input  1  asynchronous, active-low reset
- `next_instr`  input  4+2*RA_W  fetched instruction: [opcode 4 | dst RA_W | src RA_W]
- `ir_write, pc_write, reg_write, alu_write, flag_write`  input  1 each  register load enables
- `alu_sel1, alu_sel2`  input  2 each  ALU operand selects
- `alu_op`  input  `alu_operation_t`  ALU function
- `addr_sel`  input  1  memory address source: 0 = R[src], 1 = R[dst]
- `result_sel`  input  2  write-back select
- `mem_start, mem_we`  input  1 each  start memory access / access is a store
- `mem_req, mem_wr`  output  1 each  external request / write strobe
- `mem_addr, mem_wdata`  output  DATA_W each  external address / store data
- `mem_rdata`  input  DATA_W  load data
- `mem_ready`  input  1  external completion
- `mem_busy, mem_done, mem_err`  output  1 each  sequencer status
- `zero, carry`  output  1 each  registered flags
- `opcode`  output  `opcode_t`  IR opcode field
- `pc`  output  DATA_W  program counter

## Operation
- Immediates: `imm_wide` = {dst,src} zero-extended to DATA_W; `imm_narrow` = src zero-extended.
- op1 mux: 0 R[dst], 1 `imm_wide`, 2 constant 1, 3 zero. op2 mux: 0 `imm_narrow`, 1 `pc`, 2 R[src], 3 zero.
- ALU: arithmetic modulo 2^DATA_W; `carry` = bit DATA_W of add/sub (borrow for sub); `zero` = result==0. Logic ops clear carry.
- Result mux: 0 MDR, 1 `alu_out`, 2 live ALU result, 3 `imm_wide`. Result feeds reg-file write data (to R[dst]) and `next_pc`.
- Register file: two async reads (src, dst), one sync write to dst; no hardwired-zero register.
- Memory sequencer states IDLE, REQ, WAIT:
  - IDLE: `mem_start`=1 latches address (per `addr_sel`), R[dst] as wdata, `mem_we` → REQ. `mem_start` ignored outside IDLE.
  - REQ: `mem_req`=1 for one cycle; `mem_ready`=1 here completes → IDLE; else → WAIT.
  - WAIT: `mem_req` held with stable addr/data until `mem_ready`.
  - On completion edge: loads capture `mem_rdata` into MDR; `mem_done` pulses one cycle after.
- `mem_busy` = state≠IDLE. `mem_err` = `mem_done` & timeout.
- Reset values: PC, IR, `alu_out`, MDR, all registers, `zero`, `carry` = 0; state IDLE; `mem_req`, `mem_wr`, `mem_busy`, `mem_done`, `mem_err` = 0. Asserting `reset` mid-access drops `mem_req` immediately.

## Timing
- All registers update on posedge `clk` when their enable is high. Enables during `mem_busy` are honoured; the controller gates them.
- Minimum access: `mem_start` edge N, `mem_req` high in cycle N+1. `mem_ready` in N+1 → MDR valid and `mem_done` high in N+2.
- Each WAIT cycle adds one cycle of latency.
- `mem_done` and `mem_start` in the same cycle starts a new access. Back-to-back accesses: one idle cycle minimum.

## Configuration
- `DP_MEM_TIMEOUT_EN` defined:
  - A counter runs in REQ/WAIT.
  - After `TIMEOUT_CYCLES` cycles without `mem_ready`, `mem_req` drops, state → IDLE, and `mem_done`+`mem_err` pulse together.
  - MDR is unchanged.
- Undefined: WAIT holds forever; `mem_err` tied 0; no counter logic.

## Structure
- `custom_types` gains `alu_operation_t` additions (carry-producing ADD/SUB), plus `mem_state_t` and result/operand select encodings as localparams.
- Sub-module `mem_port_ctrl`: sequencer, address/data latches, MDR and timeout counter.
- Register file and ALU get parametrised variants `register_file_param` and `alu_param`, reused elsewhere.

## Test plan
- Reset with `reset`=0 mid-WAIT → `mem_req`=0 the same cycle, `pc`=0, all regs 0, flags 0.
- DATA_W=8, R[dst]=8'hFF, op1=R[dst], op2=const via `imm_narrow`=1, ADD, `flag_write` → result 8'h00, `zero`=1, `carry`=1.
- Load, R[src]=8'h12, `mem_ready` high in REQ, `mem_rdata`=8'hA5 → `mem_done` at N+2, MDR=8'hA5, write-back with `result_sel`=0 → R[dst]=8'hA5.
- Store with `mem_ready` delayed 3 cycles → `mem_req`/`mem_wr` held 4 cycles, addr/wdata stable, `mem_start` during busy ignored.
- `DP_MEM_TIMEOUT_EN`, TIMEOUT_CYCLES=4, `mem_ready` never → `mem_req` drops after 4 cycles, `mem_done`=`mem_err`=1 one cycle, MDR unchanged.
- NUM_REGS=8: write distinct values to R0–R7 and read back via both ports → all match; `opcode` tracks IR after `ir_write`.

Source files
------------

// File: rtl/param_data_path_pkg.sv
// Shared types and select encodings for the param_data_path CPU data path.
// Latency: none, declarations only.
// Backpressure: none; select codes are plain localparams so legacy controllers can drive raw values.
package param_data_path_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0, OP_LD  = 4'h1, OP_ST  = 4'h2, OP_ADD = 4'h3,
        OP_SUB = 4'h4, OP_AND = 4'h5, OP_OR  = 4'h6, OP_XOR = 4'h7,
        OP_NOT = 4'h8, OP_MOV = 4'h9, OP_LDI = 4'hA, OP_JMP = 4'hB,
        OP_JZ  = 4'hC, OP_JC  = 4'hD, OP_OUT = 4'hE, OP_HLT = 4'hF
    } opcode_t;

    // ADD and SUB are the only carry-producing functions.
    typedef enum logic [2:0] {
        ALU_ADD   = 3'd0,
        ALU_SUB   = 3'd1,
        ALU_AND   = 3'd2,
        ALU_OR    = 3'd3,
        ALU_XOR   = 3'd4,
        ALU_NOT   = 3'd5,
        ALU_PASS1 = 3'd6,
        ALU_PASS2 = 3'd7
    } alu_operation_t;

    typedef logic [1:0] mem_state_t;
    localparam mem_state_t MEM_IDLE = 2'd0;
    localparam mem_state_t MEM_REQ  = 2'd1;
    localparam mem_state_t MEM_WAIT = 2'd2;

    localparam logic [1:0] OP1_RDST = 2'd0;
    localparam logic [1:0] OP1_IMMW = 2'd1;
    localparam logic [1:0] OP1_ONE  = 2'd2;
    localparam logic [1:0] OP1_ZERO = 2'd3;

    localparam logic [1:0] OP2_IMMN = 2'd0;
    localparam logic [1:0] OP2_PC   = 2'd1;
    localparam logic [1:0] OP2_RSRC = 2'd2;
    localparam logic [1:0] OP2_ZERO = 2'd3;

    localparam logic [1:0] RES_MDR    = 2'd0;
    localparam logic [1:0] RES_ALUOUT = 2'd1;
    localparam logic [1:0] RES_ALU    = 2'd2;
    localparam logic [1:0] RES_IMMW   = 2'd3;

endpackage

// File: rtl/alu_param.sv
// Parametrised ALU with carry (borrow on SUB) and zero outputs.
// Latency: purely combinational.
// Backpressure: none.
module alu_param
    import param_data_path_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  alu_operation_t    op,
    output logic [DATA_W-1:0] y,
    output logic              carry_out,
    output logic              zero_out
);

    logic [DATA_W:0] wide;

    always_comb begin
        wide      = '0;
        y         = '0;
        carry_out = 1'b0;
        case (op)
            ALU_ADD: begin
                wide      = {1'b0, a} + {1'b0, b};
                y         = wide[DATA_W-1:0];
                carry_out = wide[DATA_W];
            end
            ALU_SUB: begin
                wide      = {1'b0, a} - {1'b0, b};
                y         = wide[DATA_W-1:0];
                carry_out = wide[DATA_W];
            end
            ALU_AND:   y = a & b;
            ALU_OR:    y = a | b;
            ALU_XOR:   y = a ^ b;
            ALU_NOT:   y = ~a;
            ALU_PASS1: y = a;
            ALU_PASS2: y = b;
            default:   y = '0;
        endcase
    end

    assign zero_out = (y == '0);

endmodule

// File: rtl/mem_port_ctrl.sv
// Data-memory access sequencer (IDLE/REQ/WAIT) with address/data latches and MDR; DP_MEM_TIMEOUT_EN adds a wait limit.
// Latency: req the cycle after start, done the cycle after the mem_ready edge (2 cycles minimum).
// Backpressure: mem_req held with stable addr/data until mem_ready; start ignored while busy.
module mem_port_ctrl
    import param_data_path_pkg::*;
#(
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              we,
    input  logic [DATA_W-1:0] addr_in,
    input  logic [DATA_W-1:0] wdata_in,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              mem_busy,
    output logic              mem_done,
    output logic              mem_err,
    output logic [DATA_W-1:0] mdr
);

    mem_state_t        state_q, state_d;
    logic [DATA_W-1:0] addr_q, addr_d, wdata_q, wdata_d, mdr_q, mdr_d;
    logic              we_q, we_d, done_q, done_d;
`ifdef DP_MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        mdr_d   = mdr_q;
        done_d  = 1'b0;
`ifdef DP_MEM_TIMEOUT_EN
        cnt_d   = '0;
        err_d   = 1'b0;
`endif
        case (state_q)
            MEM_IDLE: begin
                if (start) begin
                    state_d = MEM_REQ;
                    addr_d  = addr_in;
                    wdata_d = wdata_in;
                    we_d    = we;
                end
            end
            MEM_REQ, MEM_WAIT: begin
                if (mem_ready) begin
                    state_d = MEM_IDLE;
                    done_d  = 1'b1;
                    if (!we_q) mdr_d = mem_rdata;
                end
`ifdef DP_MEM_TIMEOUT_EN
                // Abandoned accesses leave MDR untouched.
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = MEM_IDLE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    state_d = MEM_WAIT;
                    cnt_d   = cnt_q + 1'b1;
                end
`else
                else begin
                    state_d = MEM_WAIT;
                end
`endif
            end
            default: state_d = MEM_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= MEM_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            mdr_q   <= '0;
            done_q  <= 1'b0;
`ifdef DP_MEM_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            mdr_q   <= mdr_d;
            done_q  <= done_d;
`ifdef DP_MEM_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    // Request decoded straight from state so an async reset drops it immediately.
    assign mem_req   = (state_q != MEM_IDLE);
    assign mem_busy  = (state_q != MEM_IDLE);
    assign mem_wr    = mem_req & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_done  = done_q;
    assign mdr       = mdr_q;
`ifdef DP_MEM_TIMEOUT_EN
    assign mem_err   = done_q & err_q;
`else
    assign mem_err   = 1'b0;
`endif

endmodule

// File: rtl/register_file_param.sv
// Parametrised register file: two asynchronous read ports, one synchronous write port.
// Latency: reads combinational, write visible the cycle after the enabled edge.
// Backpressure: none; writes are accepted whenever we is high.
module register_file_param #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 4,
    localparam int RA_W    = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [RA_W-1:0]   waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [RA_W-1:0]   raddr_a,
    input  logic [RA_W-1:0]   raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    always_comb begin
        regs_d = regs_q;
        if (we) regs_d[waddr] = wdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rdata_a = regs_q[raddr_a];
    assign rdata_b = regs_q[raddr_b];

endmodule

// File: rtl/param_data_path.sv
// Multicycle CPU data path: PC, IR, register file, shared ALU with flags, sequenced memory port (DP_MEM_TIMEOUT_EN adds a wait limit).
// Latency: registers load on the enabled edge; memory access 2 cycles minimum plus one per wait cycle.
// Backpressure: external memory stalls via mem_ready; the controller watches mem_busy/mem_done.
module param_data_path
    import param_data_path_pkg::*;
#(
    parameter int DATA_W         = 8,
    parameter int NUM_REGS       = 4,
    parameter int TIMEOUT_CYCLES = 15,
    localparam int RA_W          = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4+2*RA_W-1:0]   next_instr,
    input  logic                  ir_write,
    input  logic                  pc_write,
    input  logic                  reg_write,
    input  logic                  alu_write,
    input  logic                  flag_write,
    input  logic [1:0]            alu_sel1,
    input  logic [1:0]            alu_sel2,
    input  alu_operation_t        alu_op,
    input  logic                  addr_sel,
    input  logic [1:0]            result_sel,
    input  logic                  mem_start,
    input  logic                  mem_we,
    output logic                  mem_req,
    output logic                  mem_wr,
    output logic [DATA_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_ready,
    output logic                  mem_busy,
    output logic                  mem_done,
    output logic                  mem_err,
    output logic                  zero,
    output logic                  carry,
    output opcode_t               opcode,
    output logic [DATA_W-1:0]     pc
);

    localparam int INSTR_W = 4 + 2 * RA_W;

    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0]  pc_q, pc_d, alu_out_q, alu_out_d;
    logic               zero_q, zero_d, carry_q, carry_d;

    logic [RA_W-1:0]    dst, src;
    logic [DATA_W-1:0]  imm_wide, imm_narrow, r_src, r_dst, op1, op2;
    logic [DATA_W-1:0]  alu_res, mdr, result;
    logic               alu_carry, alu_zero;

    assign opcode     = opcode_t'(ir_q[INSTR_W-1 -: 4]);
    assign dst        = ir_q[2*RA_W-1 -: RA_W];
    assign src        = ir_q[RA_W-1:0];
    assign imm_wide   = DATA_W'({dst, src});
    assign imm_narrow = DATA_W'(src);

    always_comb begin
        op1 = '0;
        case (alu_sel1)
            OP1_RDST: op1 = r_dst;
            OP1_IMMW: op1 = imm_wide;
            OP1_ONE:  op1 = DATA_W'(1);
            OP1_ZERO: op1 = '0;
            default:  op1 = '0;
        endcase
        op2 = '0;
        case (alu_sel2)
            OP2_IMMN: op2 = imm_narrow;
            OP2_PC:   op2 = pc_q;
            OP2_RSRC: op2 = r_src;
            OP2_ZERO: op2 = '0;
            default:  op2 = '0;
        endcase
        result = '0;
        case (result_sel)
            RES_MDR:    result = mdr;
            RES_ALUOUT: result = alu_out_q;
            RES_ALU:    result = alu_res;
            RES_IMMW:   result = imm_wide;
            default:    result = '0;
        endcase
    end

    always_comb begin
        ir_d      = ir_write  ? next_instr : ir_q;
        pc_d      = pc_write  ? result     : pc_q;
        alu_out_d = alu_write ? alu_res    : alu_out_q;
        zero_d    = flag_write ? alu_zero  : zero_q;
        carry_d   = flag_write ? alu_carry : carry_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir_q      <= '0;
            pc_q      <= '0;
            alu_out_q <= '0;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
        end else begin
            ir_q      <= ir_d;
            pc_q      <= pc_d;
            alu_out_q <= alu_out_d;
            zero_q    <= zero_d;
            carry_q   <= carry_d;
        end
    end

    assign pc    = pc_q;
    assign zero  = zero_q;
    assign carry = carry_q;

    register_file_param #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_rf (
        .clk     (clk),
        .reset   (reset),
        .we      (reg_write),
        .waddr   (dst),
        .wdata   (result),
        .raddr_a (src),
        .raddr_b (dst),
        .rdata_a (r_src),
        .rdata_b (r_dst)
    );

    alu_param #(.DATA_W(DATA_W)) u_alu (
        .a         (op1),
        .b         (op2),
        .op        (alu_op),
        .y         (alu_res),
        .carry_out (alu_carry),
        .zero_out  (alu_zero)
    );

    mem_port_ctrl #(.DATA_W(DATA_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_mem (
        .clk       (clk),
        .reset     (reset),
        .start     (mem_start),
        .we        (mem_we),
        .addr_in   (addr_sel ? r_dst : r_src),
        .wdata_in  (r_dst),
        .mem_req   (mem_req),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .mem_busy  (mem_busy),
        .mem_done  (mem_done),
        .mem_err   (mem_err),
        .mdr       (mdr)
    );

endmodule

// File: tb/tb_param_data_path.sv
// Directed bench for param_data_path with DATA_W=8, NUM_REGS=8, TIMEOUT_CYCLES=4.
module tb_param_data_path;
    import param_data_path_pkg::*;

    logic           clk = 1'b0;
    logic           reset;
    logic [9:0]     next_instr;
    logic           ir_write, pc_write, reg_write, alu_write, flag_write;
    logic [1:0]     alu_sel1, alu_sel2, result_sel;
    alu_operation_t alu_op;
    logic           addr_sel, mem_start, mem_we;
    logic           mem_req, mem_wr, mem_ready, mem_busy, mem_done, mem_err;
    logic [7:0]     mem_addr, mem_wdata, mem_rdata, pc;
    logic           zero, carry;
    opcode_t        opcode;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    param_data_path #(.DATA_W(8), .NUM_REGS(8), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .next_instr(next_instr),
        .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
        .alu_write(alu_write), .flag_write(flag_write),
        .alu_sel1(alu_sel1), .alu_sel2(alu_sel2), .alu_op(alu_op),
        .addr_sel(addr_sel), .result_sel(result_sel),
        .mem_start(mem_start), .mem_we(mem_we),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .mem_busy(mem_busy), .mem_done(mem_done), .mem_err(mem_err),
        .zero(zero), .carry(carry), .opcode(opcode), .pc(pc)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ctrl();
        next_instr = '0; ir_write = 0; pc_write = 0; reg_write = 0; alu_write = 0; flag_write = 0;
        alu_sel1 = OP1_RDST; alu_sel2 = OP2_IMMN; alu_op = ALU_ADD; addr_sel = 0;
        result_sel = RES_MDR; mem_start = 0; mem_we = 0; mem_rdata = '0; mem_ready = 0;
    endtask

    task automatic set_ir(input logic [3:0] op, input logic [2:0] d, input logic [2:0] s);
        next_instr = {op, d, s}; ir_write = 1; tick(); ir_write = 0;
    endtask

    task automatic load_reg(input logic [2:0] d, input logic [7:0] v);
        set_ir(4'h1, d, 3'd0);
        addr_sel = 0; mem_we = 0; mem_start = 1; tick(); mem_start = 0;
        mem_ready = 1; mem_rdata = v; tick(); mem_ready = 0; mem_rdata = '0;
        result_sel = RES_MDR; reg_write = 1; tick(); reg_write = 0;
    endtask

    // Store with addr_sel=0 exposes R[s] on mem_addr and R[d] on mem_wdata.
    task automatic peek_regs(input logic [2:0] d, input logic [2:0] s,
                             output logic [7:0] rs, output logic [7:0] rd);
        set_ir(4'h2, d, s);
        addr_sel = 0; mem_we = 1; mem_start = 1; tick(); mem_start = 0; mem_we = 0;
        rs = mem_addr; rd = mem_wdata;
        mem_ready = 1; tick(); mem_ready = 0; tick();
    endtask

    task automatic pc_from(input logic [1:0] sel);
        result_sel = sel; pc_write = 1; tick(); pc_write = 0;
    endtask

    task automatic test_reset();
        reset = 0; idle_ctrl(); tick(); tick();
        checks++; if ({mem_req, mem_wr, mem_busy, mem_done, mem_err} !== 5'b0) begin errors++;
            $display("FAIL reset_mem_status: got %b expected 00000", {mem_req, mem_wr, mem_busy, mem_done, mem_err}); end
        checks++; if (pc !== 8'h00) begin errors++; $display("FAIL reset_pc: got %h expected 00", pc); end
        checks++; if ({zero, carry} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected 00", {zero, carry}); end
        checks++; if (opcode !== 4'h0) begin errors++; $display("FAIL reset_opcode: got %h expected 0", opcode); end
        checks++; if ({mem_addr, mem_wdata} !== 16'h0) begin errors++; $display("FAIL reset_addr_data: got %h expected 0000", {mem_addr, mem_wdata}); end
        reset = 1; tick();
    endtask

    task automatic test_alu();
        logic [7:0] rs, rd;
        load_reg(3'd1, 8'hFF);
        set_ir(4'h3, 3'd1, 3'd1);
        alu_sel1 = OP1_RDST; alu_sel2 = OP2_IMMN; alu_op = ALU_ADD;
        flag_write = 1; alu_write = 1; result_sel = RES_ALU; reg_write = 1; tick();
        flag_write = 0; alu_write = 0; reg_write = 0;
        checks++; if ({zero, carry} !== 2'b11) begin errors++; $display("FAIL add_ff_flags: got zc=%b expected 11", {zero, carry}); end
        peek_regs(3'd1, 3'd1, rs, rd);
        checks++; if (rd !== 8'h00) begin errors++; $display("FAIL add_ff_result: got %h expected 00", rd); end
        alu_sel1 = OP1_RDST; alu_sel2 = OP2_IMMN; alu_op = ALU_SUB; flag_write = 1;
        pc_from(RES_ALU); flag_write = 0;
        checks++; if ({pc, zero, carry} !== {8'hFF, 2'b01}) begin errors++;
            $display("FAIL sub_borrow: got pc=%h zc=%b expected FF 01", pc, {zero, carry}); end
        alu_sel1 = OP1_IMMW; alu_sel2 = OP2_PC; alu_op = ALU_AND; flag_write = 1; alu_write = 1; tick();
        flag_write = 0; alu_write = 0;
        pc_from(RES_ALUOUT);
        checks++; if ({pc, zero, carry} !== {8'h09, 2'b00}) begin errors++;
            $display("FAIL and_aluout: got pc=%h zc=%b expected 09 00", pc, {zero, carry}); end
        alu_sel1 = OP1_ONE; alu_sel2 = OP2_RSRC; alu_op = ALU_ADD; pc_from(RES_ALU);
        checks++; if (pc !== 8'h01) begin errors++; $display("FAIL one_plus_rsrc: got %h expected 01", pc); end
        alu_sel1 = OP1_ZERO; alu_sel2 = OP2_ZERO; alu_op = ALU_OR; flag_write = 1; tick(); flag_write = 0;
        checks++; if ({zero, carry} !== 2'b10) begin errors++; $display("FAIL or_zero_flags: got zc=%b expected 10", {zero, carry}); end
        set_ir(4'h0, 3'd5, 3'd3); pc_from(RES_IMMW);
        checks++; if (pc !== 8'h2B) begin errors++; $display("FAIL imm_wide_pc: got %h expected 2b", pc); end
        idle_ctrl();
    endtask

    task automatic test_load();
        logic [7:0] rs, rd;
        load_reg(3'd2, 8'h12);
        set_ir(4'h1, 3'd3, 3'd2);
        addr_sel = 0; mem_we = 0; mem_start = 1; tick(); mem_start = 0;
        checks++; if ({mem_req, mem_wr, mem_busy, mem_done, mem_addr} !== {4'b1010, 8'h12}) begin errors++;
            $display("FAIL load_req: got req/wr/busy/done=%b addr=%h expected 1010 12", {mem_req, mem_wr, mem_busy, mem_done}, mem_addr); end
        mem_ready = 1; mem_rdata = 8'hA5; tick(); mem_ready = 0; mem_rdata = '0;
        checks++; if ({mem_req, mem_busy, mem_done, mem_err} !== 4'b0010) begin errors++;
            $display("FAIL load_done: got req/busy/done/err=%b expected 0010", {mem_req, mem_busy, mem_done, mem_err}); end
        result_sel = RES_MDR; reg_write = 1; tick(); reg_write = 0;
        checks++; if (mem_done !== 1'b0) begin errors++; $display("FAIL load_done_pulse: got %b expected 0", mem_done); end
        peek_regs(3'd3, 3'd2, rs, rd);
        checks++; if ({rd, rs} !== 16'hA512) begin errors++; $display("FAIL load_writeback: got %h expected a512", {rd, rs}); end
    endtask

    task automatic test_store_wait();
        load_reg(3'd4, 8'h3C);
        load_reg(3'd5, 8'h77);
        set_ir(4'h2, 3'd4, 3'd5);
        addr_sel = 0; mem_we = 1; mem_start = 1; tick(); mem_start = 0; mem_rdata = 8'hEE;
        for (int c = 0; c < 4; c++) begin
            checks++; if ({mem_req, mem_wr, mem_addr, mem_wdata} !== {2'b11, 8'h77, 8'h3C}) begin errors++;
                $display("FAIL store_hold_%0d: got req/wr=%b addr=%h data=%h expected 11 77 3c", c, {mem_req, mem_wr}, mem_addr, mem_wdata); end
            if (c == 1) begin
                mem_start = 1; mem_we = 0; next_instr = {4'h0, 3'd6, 3'd6}; ir_write = 1;
            end else begin
                mem_start = 0; ir_write = 0;
            end
            mem_ready = (c == 3);
            tick();
        end
        mem_ready = 0; mem_rdata = '0; mem_we = 0;
        checks++; if ({mem_req, mem_wr, mem_done} !== 3'b001) begin errors++;
            $display("FAIL store_done: got req/wr/done=%b expected 001", {mem_req, mem_wr, mem_done}); end
        tick();
        checks++; if ({mem_req, mem_busy, mem_done} !== 3'b000) begin errors++;
            $display("FAIL store_start_ignored: got req/busy/done=%b expected 000", {mem_req, mem_busy, mem_done}); end
        pc_from(RES_MDR);
        checks++; if (pc !== 8'h77) begin errors++; $display("FAIL store_mdr_kept: got %h expected 77", pc); end
    endtask

    task automatic test_back_to_back();
        set_ir(4'h1, 3'd3, 3'd2);
        addr_sel = 0; mem_we = 0; mem_start = 1; tick(); mem_start = 0;
        mem_ready = 1; mem_rdata = 8'h5C; tick();
        checks++; if (mem_done !== 1'b1) begin errors++; $display("FAIL b2b_first_done: got %b expected 1", mem_done); end
        addr_sel = 1; mem_start = 1; mem_ready = 0; tick(); mem_start = 0;
        checks++; if ({mem_req, mem_wr, mem_addr} !== {2'b10, 8'hA5}) begin errors++;
            $display("FAIL b2b_second_req: got req/wr=%b addr=%h expected 10 a5", {mem_req, mem_wr}, mem_addr); end
        mem_ready = 1; mem_rdata = 8'hC3; tick(); mem_ready = 0; mem_rdata = '0;
        checks++; if (mem_done !== 1'b1) begin errors++; $display("FAIL b2b_second_done: got %b expected 1", mem_done); end
        pc_from(RES_MDR);
        checks++; if (pc !== 8'hC3) begin errors++; $display("FAIL b2b_mdr: got %h expected c3", pc); end
        addr_sel = 0;
    endtask

    task automatic test_wait_limit();
        load_reg(3'd6, 8'h5A);
        set_ir(4'h1, 3'd6, 3'd0);
        addr_sel = 1; mem_we = 0; mem_start = 1; tick(); mem_start = 0; mem_rdata = 8'h99;
`ifdef DP_MEM_TIMEOUT_EN
        for (int c = 0; c < 4; c++) begin
            checks++; if ({mem_req, mem_done, mem_addr} !== {2'b10, 8'h5A}) begin errors++;
                $display("FAIL timeout_wait_%0d: got req/done=%b addr=%h expected 10 5a", c, {mem_req, mem_done}, mem_addr); end
            tick();
        end
        checks++; if ({mem_req, mem_done, mem_err} !== 3'b011) begin errors++;
            $display("FAIL timeout_pulse: got req/done/err=%b expected 011", {mem_req, mem_done, mem_err}); end
        tick();
        checks++; if ({mem_busy, mem_done, mem_err} !== 3'b000) begin errors++;
            $display("FAIL timeout_after: got busy/done/err=%b expected 000", {mem_busy, mem_done, mem_err}); end
        pc_from(RES_MDR);
        checks++; if (pc !== 8'h5A) begin errors++; $display("FAIL timeout_mdr_kept: got %h expected 5a", pc); end
`else
        for (int c = 0; c < 20; c++) begin
            checks++; if ({mem_req, mem_err, mem_addr} !== {2'b10, 8'h5A}) begin errors++;
                $display("FAIL long_wait_%0d: got req/err=%b addr=%h expected 10 5a", c, {mem_req, mem_err}, mem_addr); end
            tick();
        end
        mem_ready = 1; tick(); mem_ready = 0; mem_rdata = '0;
        checks++; if ({mem_done, mem_err} !== 2'b10) begin errors++;
            $display("FAIL long_wait_done: got done/err=%b expected 10", {mem_done, mem_err}); end
        pc_from(RES_MDR);
        checks++; if (pc !== 8'h99) begin errors++; $display("FAIL long_wait_mdr: got %h expected 99", pc); end
`endif
        mem_rdata = '0; addr_sel = 0;
    endtask

    task automatic test_regfile();
        logic [7:0] vals [8];
        logic [7:0] rs, rd;
        vals = '{8'h0F, 8'h1E, 8'h2D, 8'h3C, 8'h4B, 8'h5A, 8'h69, 8'h78};
        for (int i = 0; i < 8; i++) load_reg(3'(i), vals[i]);
        for (int i = 0; i < 8; i++) begin
            peek_regs(3'(i), 3'(7 - i), rs, rd);
            checks++; if (rd !== vals[i]) begin errors++; $display("FAIL regfile_dst_r%0d: got %h expected %h", i, rd, vals[i]); end
            checks++; if (rs !== vals[7-i]) begin errors++; $display("FAIL regfile_src_r%0d: got %h expected %h", 7 - i, rs, vals[7-i]); end
        end
    endtask

    task automatic test_opcode();
        set_ir(4'hA, 3'd1, 3'd2);
        checks++; if (opcode !== 4'hA) begin errors++; $display("FAIL opcode_load: got %h expected a", opcode); end
        next_instr = {4'h5, 3'd0, 3'd0}; tick();
        checks++; if (opcode !== 4'hA) begin errors++; $display("FAIL opcode_hold: got %h expected a", opcode); end
        set_ir(4'h3, 3'd0, 3'd0);
        checks++; if (opcode !== 4'h3) begin errors++; $display("FAIL opcode_reload: got %h expected 3", opcode); end
    endtask

    task automatic test_reset_mid_wait();
        logic [7:0] rs, rd;
        set_ir(4'h4, 3'd0, 3'd1);
        alu_sel1 = OP1_ZERO; alu_sel2 = OP2_IMMN; alu_op = ALU_SUB; flag_write = 1;
        pc_from(RES_ALU); flag_write = 0;
        set_ir(4'h1, 3'd7, 3'd7);
        addr_sel = 0; mem_we = 0; mem_start = 1; tick(); mem_start = 0; tick();
        checks++; if ({mem_req, carry, pc} !== {2'b11, 8'hFF}) begin errors++;
            $display("FAIL prereset_state: got req/carry=%b pc=%h expected 11 ff", {mem_req, carry}, pc); end
        #2 reset = 0;
        #1;
        checks++; if ({mem_req, mem_busy} !== 2'b00) begin errors++;
            $display("FAIL midwait_reset_req: got req/busy=%b expected 00", {mem_req, mem_busy}); end
        checks++; if ({pc, zero, carry} !== 10'h0) begin errors++;
            $display("FAIL midwait_reset_pc_flags: got pc=%h zc=%b expected 00 00", pc, {zero, carry}); end
        idle_ctrl(); tick(); reset = 1; tick();
        for (int i = 0; i < 8; i++) begin
            peek_regs(3'(i), 3'(7 - i), rs, rd);
            checks++; if ({rd, rs} !== 16'h0) begin errors++; $display("FAIL reset_regs_%0d: got %h expected 0000", i, {rd, rs}); end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store_wait();
        test_back_to_back();
        test_wait_limit();
        test_regfile();
        test_opcode();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
